// File: rtl/sram_wb_dma_v2.sv
// Byte-addressed frame-buffer SRAM shared by a Wishbone CPU port and a streaming DMA write port.
// Wishbone writes win arbitration; Wishbone reads never stall the stream.
module sram_wb_dma_v2 #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 65536,
  parameter logic [3:0]  REGION = 4'h2,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dma_start,
  input  logic [ADDR_W-1:0] dma_start_addr,
  input  logic              dma_valid,
  input  logic [7:0]        dma_data,
  output logic              dma_ready,
  output logic [ADDR_W:0]   dma_count,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [31:0]       wb_addr,
  input  logic [3:0]        wb_sel,
  input  logic [31:0]       wb_wdata,
  output logic [31:0]       wb_rdata,
  output logic              wb_ack,
  output logic              wb_err
);
  localparam int unsigned       IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        LAT_INIT = 2'(RD_LAT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [7:0]        mem [DEPTH];
  state_t            state;
  logic [1:0]        lat_cnt;
  logic              pend_err;
  logic [31:0]       pend_data;
  logic [ADDR_W-1:0] ptr;

  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  base;
  logic              hit, oor, accept, wr_accept, dma_xfer;
  logic              fire, fire_err;
  logic [31:0]       rd_word, resp_data, fire_data;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{wb_addr[27:ADDR_W], wb_addr[1:0]};

  always_comb begin
    // NOTE: every path assigns every signal of this block, so no latch is inferred.
    offset    = {wb_addr[ADDR_W-1:2], 2'b00};
    base      = offset[IDX_W-1:0];
    hit       = wb_cyc && wb_stb && (wb_addr[31:28] == REGION);
    oor       = {1'b0, offset} >= DEPTH_L;
    accept    = rst_n && (state == S_IDLE) && hit && !wb_ack && !wb_err;
    wr_accept = accept && wb_we;
    dma_ready = rst_n && !dma_start && !wr_accept;
    dma_xfer  = dma_valid && dma_ready;
    // Sampled before this edge's writes land, so a colliding DMA byte reads back old.
    rd_word   = {mem[base + IDX_W'(3)], mem[base + IDX_W'(2)],
                 mem[base + IDX_W'(1)], mem[base]};
    resp_data = (wb_we || oor) ? '0 : rd_word;
    if (state == S_IDLE) begin
      fire      = accept && (RD_LAT == 1);
      fire_err  = oor;
      fire_data = resp_data;
    end else begin
      fire      = (lat_cnt == 2'd1);
      fire_err  = pend_err;
      fire_data = pend_data;
    end
  end

  // Response registers go high on the edge that ends cycle RD_LAT-1 after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lat_cnt   <= '0;
      pend_err  <= 1'b0;
      pend_data <= '0;
      wb_ack    <= 1'b0;
      wb_err    <= 1'b0;
      wb_rdata  <= '0;
    end else begin
      // NOTE: non-blocking so every block samples pre-edge values of these registers.
      wb_ack   <= fire && !fire_err;
      wb_err   <= fire && fire_err;
      wb_rdata <= fire ? fire_data : '0;
      case (state)
        S_IDLE: if (accept) begin
          state     <= S_WAIT;
          lat_cnt   <= LAT_INIT;
          pend_err  <= oor;
          pend_data <= resp_data;
        end
        S_WAIT: begin
          if (lat_cnt == 2'd0) state <= S_IDLE;
          else                 lat_cnt <= lat_cnt - 2'd1;
        end
      endcase
    end
  end

  // NOTE: the array has no reset; its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_accept && !oor) begin
      for (int n = 0; n < 4; n++) begin
        if (wb_sel[n]) mem[base + IDX_W'(n)] <= wb_wdata[8*n +: 8];
      end
    end
    if (dma_xfer) mem[ptr[IDX_W-1:0]] <= dma_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      dma_count <= '0;
    end else if (dma_start) begin
      ptr       <= ({1'b0, dma_start_addr} >= DEPTH_L) ? '0 : dma_start_addr;
      dma_count <= '0;
    end else if (dma_xfer) begin
      ptr <= (ptr == LAST_PTR) ? '0 : ptr + ADDR_W'(1);
      if (!(&dma_count)) dma_count <= dma_count + (ADDR_W+1)'(1);
    end
  end

endmodule

// File: tb/tb_sram_wb_dma_v2.sv
// Directed bench: instance A (DEPTH 16, RD_LAT 4) exercises DMA; instance B (DEPTH 1024,
// RD_LAT 3) exercises masked writes, range errors and decode.
module tb_sram_wb_dma_v2;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        dma_start, dma_valid;
  logic [7:0]  dma_start_addr, dma_data;
  logic        a_dma_ready;
  logic [8:0]  a_dma_count;
  logic        unused_b_ready;
  logic [12:0] unused_b_count;
  logic        cyc_a, cyc_b, stb, we;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic [31:0] a_rdata, b_rdata;
  logic        a_ack, a_err, b_ack, b_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd;
  logic        ack, err, got;
  int          lat;
  logic [7:0]  stream [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  sram_wb_dma_v2 #(.ADDR_W(8), .DEPTH(16), .REGION(4'h2), .RD_LAT(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .dma_start(dma_start), .dma_start_addr(dma_start_addr), .dma_valid(dma_valid),
    .dma_data(dma_data), .dma_ready(a_dma_ready), .dma_count(a_dma_count),
    .wb_cyc(cyc_a), .wb_stb(stb), .wb_we(we), .wb_addr(addr), .wb_sel(sel),
    .wb_wdata(wdata), .wb_rdata(a_rdata), .wb_ack(a_ack), .wb_err(a_err)
  );

  sram_wb_dma_v2 #(.ADDR_W(12), .DEPTH(1024), .REGION(4'h2), .RD_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .dma_start(1'b0), .dma_start_addr(12'h000), .dma_valid(1'b0),
    .dma_data(8'h00), .dma_ready(unused_b_ready), .dma_count(unused_b_count),
    .wb_cyc(cyc_b), .wb_stb(stb), .wb_we(we), .wb_addr(addr), .wb_sel(sel),
    .wb_wdata(wdata), .wb_rdata(b_rdata), .wb_ack(b_ack), .wb_err(b_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One Wishbone access; accept lands on the next edge, lat counts cycles to the response.
  task automatic wb_xfer(input bit to_b, input bit wr, input logic [31:0] adr,
                         input logic [3:0] be, input logic [31:0] dat);
    cyc_a = !to_b; cyc_b = to_b; stb = 1'b1; we = wr; addr = adr; sel = be; wdata = dat;
    ack = 1'b0; err = 1'b0; rd = '0; lat = 0;
    @(posedge clk); #1;
    cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; we = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (to_b ? (b_ack || b_err) : (a_ack || a_err)) begin
        ack = to_b ? b_ack : a_ack;
        err = to_b ? b_err : a_err;
        rd  = to_b ? b_rdata : a_rdata;
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; dma_start = 1'b0; dma_start_addr = '0; dma_valid = 1'b0; dma_data = '0;
    cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_ready", 32'(a_dma_ready), 0);
    check("rst_resp", 32'({a_ack, a_err, b_ack, b_err}), 0);
    check("rst_rdata", a_rdata | b_rdata, 0);
    check("rst_count", 32'(a_dma_count), 0);
    rst_n = 1'b1; #1;
    check("ready_after_rst", 32'(a_dma_ready), 1);
    @(posedge clk); #1;

    // Masked write and read latency on B
    wb_xfer(1'b1, 1'b1, 32'h2000_0010, 4'hF, 32'h0);
    check("b_clear_ack", 32'(ack), 1);
    wb_xfer(1'b1, 1'b1, 32'h2000_0010, 4'b0101, 32'hDEAD_BEEF);
    check("b_mask_wr_lat", lat, 3);
    wb_xfer(1'b1, 1'b0, 32'h2000_0010, 4'h0, 32'h0);
    check("b_rd_lat", lat, 3);
    check("b_rd_ack", 32'(ack), 1);
    check("b_rd_data", rd, 32'h00AD_00EF);
    check("b_ack_pulse", 32'(b_ack), 0);
    check("b_rdata_idle", b_rdata, 0);
    wb_xfer(1'b1, 1'b1, 32'h2000_0010, 4'h0, 32'h1234_5678);
    check("b_sel0_ack", 32'(ack), 1);
    wb_xfer(1'b1, 1'b0, 32'h2000_0010, 4'h0, 32'h0);
    check("b_sel0_nowrite", rd, 32'h00AD_00EF);

    // Out of range and decode miss on B
    wb_xfer(1'b1, 1'b1, 32'h2000_0000, 4'hF, 32'h0102_0304);
    wb_xfer(1'b1, 1'b1, 32'h2000_0400, 4'hF, 32'hFFFF_FFFF);
    check("b_oor_wr_resp", 32'({ack, err}), 32'h1);
    wb_xfer(1'b1, 1'b0, 32'h2000_0400, 4'h0, 32'h0);
    check("b_oor_rd_resp", 32'({ack, err}), 32'h1);
    check("b_oor_rd_lat", lat, 3);
    check("b_oor_rd_data", rd, 0);
    wb_xfer(1'b1, 1'b0, 32'h2000_0000, 4'h0, 32'h0);
    check("b_oor_no_commit", rd, 32'h0102_0304);
    wb_xfer(1'b1, 1'b0, 32'h3000_0000, 4'h0, 32'h0);
    check("b_miss_no_resp", 32'({ack, err}), 0);
    check("b_miss_lat", lat, 0);

    // DMA wrap on A, with a start-cycle byte that must not land
    wb_xfer(1'b0, 1'b1, 32'h2000_0000, 4'hF, 32'hAABB_CCDD);
    check("a_wr_lat", lat, 4);
    wb_xfer(1'b0, 1'b1, 32'h2000_000C, 4'hF, 32'h0);
    dma_start = 1'b1; dma_start_addr = 8'd14; dma_valid = 1'b1; dma_data = 8'h99; #1;
    check("start_ready", 32'(a_dma_ready), 0);
    @(posedge clk); #1;
    dma_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dma_data = stream[i]; #1;
      check("stream_ready", 32'(a_dma_ready), 1);
      @(posedge clk); #1;
    end
    dma_valid = 1'b0;
    check("wrap_count", 32'(a_dma_count), 4);
    wb_xfer(1'b0, 1'b0, 32'h2000_0000, 4'h0, 32'h0);
    check("a_rd_lat", lat, 4);
    check("wrap_low", rd, 32'hAABB_4433);
    wb_xfer(1'b0, 1'b0, 32'h2000_000C, 4'h0, 32'h0);
    check("wrap_high", rd, 32'h2211_0000);

    // Wishbone write collides with an offered DMA byte
    dma_valid = 1'b1; dma_data = 8'h61;
    cyc_a = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h2000_0004; sel = 4'hF;
    wdata = 32'h7071_7273; #1;
    check("collide_ready", 32'(a_dma_ready), 0);
    @(posedge clk); #1;
    cyc_a = 1'b0; stb = 1'b0; we = 1'b0; #1;
    check("post_collide_ready", 32'(a_dma_ready), 1);
    @(posedge clk); #1;
    dma_data = 8'h62;
    @(posedge clk); #1;
    dma_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (a_ack) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("collide_wr_ack", 32'(got), 1);
    @(posedge clk); #1;
    check("collide_count", 32'(a_dma_count), 6);
    wb_xfer(1'b0, 1'b0, 32'h2000_0000, 4'h0, 32'h0);
    check("collide_dma_bytes", rd, 32'h6261_4433);
    wb_xfer(1'b0, 1'b0, 32'h2000_0004, 4'h0, 32'h0);
    check("collide_wb_word", rd, 32'h7071_7273);

    // dma_start beats a same-cycle transfer; out-of-range start address loads 0
    dma_start = 1'b1; dma_start_addr = 8'd8; dma_valid = 1'b1; dma_data = 8'h55; #1;
    check("prio_ready", 32'(a_dma_ready), 0);
    @(posedge clk); #1;
    dma_start = 1'b0; dma_valid = 1'b0;
    check("prio_count", 32'(a_dma_count), 0);
    wb_xfer(1'b0, 1'b0, 32'h2000_0004, 4'h0, 32'h0);
    check("prio_no_write", rd, 32'h7071_7273);
    dma_start = 1'b1; dma_start_addr = 8'hF0;
    @(posedge clk); #1;
    dma_start = 1'b0; dma_valid = 1'b1; dma_data = 8'h77;
    @(posedge clk); #1;
    dma_valid = 1'b0;
    check("far_start_count", 32'(a_dma_count), 1);
    wb_xfer(1'b0, 1'b0, 32'h2000_0000, 4'h0, 32'h0);
    check("far_start_to_zero", rd, 32'h6261_4477);

    // Reset while a read waits in the latency pipeline
    cyc_a = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h2000_0004; sel = 4'h0;
    @(posedge clk); #1;
    cyc_a = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    got = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (a_ack || a_err) got = 1'b1;
    end
    check("no_resp_after_rst", 32'(got), 0);
    check("count_after_rst", 32'(a_dma_count), 0);
    wb_xfer(1'b0, 1'b0, 32'h2000_0004, 4'h0, 32'h0);
    check("mem_survives_rst", rd, 32'h7071_7273);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_wb_dma_v2.md
# sram_wb_dma_v2

Parametrised successor to the single-port byte SRAM used as the frame buffer between the capture DMA and the Wishbone CPU bus. It adds:
- a streaming DMA write port with valid/ready handshake and an auto-incrementing address pointer;
- Wishbone byte selects and an error response for out-of-range accesses;
- configurable read latency and region decode;
- deterministic arbitration between DMA and CPU writes.

## Interface
Parameters:
- ADDR_W, 16: byte-address width of the array.
- DEPTH, 65536: array size in bytes; must be a multiple of 4 and ≤ 2^ADDR_W.
- REGION, 4'h2: value matched against wb_addr[31:28].
- RD_LAT, 1: cycles from Wishbone accept to ack; legal range 1..4.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dma_start  in  1  one-cycle pulse; loads the pointer from dma_start_addr and clears dma_count.
- dma_start_addr  in  ADDR_W  starting byte address for the stream.
- dma_valid  in  1  a byte is offered on dma_data.
- dma_data  in  8  stream byte.
- dma_ready  out  1  the block accepts the byte this cycle.
- dma_count  out  ADDR_W+1  bytes written since the last dma_start; saturates at all-ones.
- wb_cyc, wb_stb, wb_we  in  1 each  Wishbone classic controls.
- wb_addr  in  32  byte address; bits [1:0] are ignored.
- wb_sel  in  4  byte lane enables for writes.
- wb_wdata  in  32  write data, little-endian lanes.
- wb_rdata  out  32  read data; valid only while wb_ack is high.
- wb_ack  out  1  one-cycle completion pulse.
- wb_err  out  1  one-cycle error pulse, sent instead of wb_ack.

## Operation
- **Decode:** hit = wb_cyc & wb_stb & (wb_addr[31:28] == REGION). The word offset is the byte address wb_addr[ADDR_W-1:2] scaled ×4. An access is out of range if offset+3 ≥ DEPTH.
- **Wishbone FSM:** IDLE → WAIT → IDLE.
  - Accept happens in IDLE when hit is high and wb_ack/wb_err is not high that cycle. The FSM moves to WAIT with a latency counter loaded with RD_LAT-1.
  - If RD_LAT==1, the response is issued on the cycle after accept and the FSM returns to IDLE. Otherwise the counter decrements in WAIT and the response fires when it reaches 0.
  - Only one transaction is outstanding. A new accept is possible no earlier than the cycle after the response.
- **Writes:** commit on the accept cycle, one byte per set wb_sel bit (lane n maps to offset+n). When wb_sel = 0 the access still acks and writes nothing. Out-of-range writes do not commit and respond with wb_err.
- **Reads:** sample {mem[offset+3] .. mem[offset]} on the accept cycle. The sample is carried through the latency pipeline and driven on wb_rdata with the ack. wb_rdata is 0 on every other cycle. Out-of-range reads return wb_err with wb_rdata = 0.
- **DMA stream:**
  - A byte transfers when dma_valid & dma_ready. It is written to mem[ptr]; ptr advances by 1 and wraps to 0 past DEPTH-1. dma_count increments and saturates.
  - dma_start has priority over a transfer in the same cycle: pointer loads, count clears, and that cycle's byte is not written. dma_start_addr ≥ DEPTH loads 0.
- **Arbitration:** Wishbone writes win.
  - dma_ready = 0 in any cycle where a Wishbone write is accepted, and also during reset and during a dma_start cycle. Otherwise dma_ready = 1.
  - Wishbone reads never stall DMA. A read accepted in the same cycle as a DMA write to a byte it covers returns the old byte.
- **Memory:** contents are not reset. Simulation initialises the array to 0 at time zero.

## Timing
- **Reset values:** wb_ack = 0, wb_err = 0, wb_rdata = 0, dma_ready = 0, dma_count = 0, pointer = 0, FSM = IDLE, latency pipeline cleared.
- **Reset during WAIT:** the pending response is dropped and no ack is ever issued for it. A write already committed stays committed.
- **Response timing:** ack/err is asserted exactly RD_LAT cycles after the accept edge, for one cycle only.
- **Per-transaction period:** minimum RD_LAT+1 cycles.
- **DMA throughput:** 1 byte per cycle when there is no Wishbone write.
- **DMA visibility:** dma_count and the pointer update on the edge that completes the transfer. A byte written by DMA is visible to a Wishbone read accepted on the next cycle or later.

## Test plan
- **Reset outputs:** reset, then release → all outputs at reset values; dma_ready = 1 on the first cycle after release.
- **Masked write and read latency:** RD_LAT = 3. Write 0xDEADBEEF to 0x2000_0010 with sel = 4'b0101, after first writing 0 there. Then read → ack exactly 3 cycles after accept, rdata = 0x00AD00EF.
- **DMA wrap:** DEPTH = 16, dma_start_addr = 14, stream 4 bytes 0x11..0x44 → bytes land at 14, 15, 0, 1; dma_count = 4. Wishbone read at offset 0 returns 0x????4433 with the upper bytes unchanged.
- **Write collision:** Wishbone write accepted while dma_valid is high → dma_ready = 0 that cycle only. The DMA byte is written the next cycle and the pointer does not skip.
- **Out of range and decode miss:** DEPTH = 1024, read 0x2000_0400 → wb_err pulse, wb_ack = 0, rdata = 0. Address 0x3000_0000 → no response at all.
- **Reset mid-WAIT and start priority:** with RD_LAT = 4, assert rst_n low in WAIT → no ack after release. Assert dma_start and dma_valid in the same cycle → no write, count = 0.
